// File: rtl/cmn_plru_victim_sel.sv
// PLRU victim selector: prefers the lowest free entry, otherwise walks the PLRU tree
// around ineligible subtrees. Define CMN_PLRU_VICTIM_LOCK_EN to let entry_lock pin entries.
module cmn_plru_victim_sel #(
  parameter int WIDTH = 4,
  parameter int DEPTH = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] entry_vld,
  input  logic [WIDTH-1:0] entry_lock,
  input  logic [WIDTH-2:0] node_q,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic [WIDTH-1:0] gnt_oh,
  output logic             gnt_evict,
  input  logic             touch_en,
  input  logic [WIDTH-1:0] touch_oh,
  output logic             plru_upd_en,
  output logic [WIDTH-1:0] plru_upd_oh
);

  typedef enum logic [0:0] {IDLE = 1'b0, GNT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] elig, free_mask, cand_oh;
  logic             cand_evict, any_elig, accept, fire;
  logic [WIDTH-1:0] gnt_oh_reg, pend_oh_reg, upd_oh_reg;
  logic             gnt_evict_reg, pend_vld_reg, upd_en_reg;

`ifdef CMN_PLRU_VICTIM_LOCK_EN
  assign elig = ~entry_lock;
`else
  logic unused_lock;
  assign unused_lock = ^entry_lock;
  assign elig        = '1;
`endif

  // True when any eligible entry lives in the subtree whose index prefix is p
  // (entry index shifted right by shift equals p).
  function automatic logic sub_any(input logic [WIDTH-1:0] mask, input int p, input int shift);
    logic [WIDTH-1:0] s;
    sub_any = 1'b0;
    for (int e = 0; e < WIDTH; e++) begin
      s = mask >> e;
      if (s[0] && ((e >> shift) == p)) sub_any = 1'b1;
    end
  endfunction

  function automatic logic [WIDTH-1:0] tree_walk(input logic [WIDTH-2:0] nodes,
                                                 input logic [WIDTH-1:0] mask);
    int              prefix;
    logic            dir;
    logic [WIDTH-2:0] ns;
    prefix = 0;
    for (int lvl = 0; lvl < DEPTH; lvl++) begin
      ns  = nodes >> ((1 << lvl) + prefix - 1);
      dir = ns[0];
      if (!sub_any(mask, 2 * prefix + (dir ? 1 : 0), DEPTH - lvl - 1)) dir = ~dir;
      prefix = 2 * prefix + (dir ? 1 : 0);
    end
    tree_walk = {{(WIDTH-1){1'b0}}, 1'b1} << prefix;
  endfunction

  assign free_mask  = ~entry_vld & elig;
  assign any_elig   = |elig;
  assign cand_evict = ~|free_mask;
  // Isolating the lowest set bit gives the lowest-index free entry.
  assign cand_oh    = cand_evict ? tree_walk(node_q, elig)
                                 : (free_mask & (~free_mask + {{(WIDTH-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = GNT;
      GNT:     if (fire)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_rdy = 1'b0;
    gnt_vld = 1'b0;
    case (state_reg)
      IDLE:    req_rdy = any_elig;
      GNT:     gnt_vld = ~pend_vld_reg;
      default: ;
    endcase
  end

  assign accept = req_vld & req_rdy;
  assign fire   = gnt_vld & gnt_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_oh_reg    <= '0;
      gnt_evict_reg <= 1'b0;
    end else if (accept) begin
      gnt_oh_reg    <= cand_oh;
      gnt_evict_reg <= cand_evict;
    end else if (fire) begin
      gnt_oh_reg    <= '0;
      gnt_evict_reg <= 1'b0;
    end
  end

  // Update arbitration: allocation beats pending touch beats fresh touch.
  // A fire only happens with pending empty, so a losing touch always fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en_reg   <= 1'b0;
      upd_oh_reg   <= '0;
      pend_vld_reg <= 1'b0;
      pend_oh_reg  <= '0;
    end else begin
      upd_en_reg <= 1'b0;
      upd_oh_reg <= '0;
      if (fire) begin
        upd_en_reg <= 1'b1;
        upd_oh_reg <= gnt_oh_reg;
        if (touch_en) begin
          pend_vld_reg <= 1'b1;
          pend_oh_reg  <= touch_oh;
        end
      end else if (pend_vld_reg) begin
        upd_en_reg   <= 1'b1;
        upd_oh_reg   <= pend_oh_reg;
        pend_vld_reg <= touch_en;
        pend_oh_reg  <= touch_en ? touch_oh : '0;
      end else if (touch_en) begin
        upd_en_reg <= 1'b1;
        upd_oh_reg <= touch_oh;
      end
    end
  end

  assign gnt_oh      = gnt_oh_reg;
  assign gnt_evict   = gnt_evict_reg;
  assign plru_upd_en = upd_en_reg;
  assign plru_upd_oh = upd_oh_reg;

endmodule

// File: doc/cmn_plru_victim_sel.md
CMN_PLRU_VICTIM_SEL -- requirements
Module: cmn_plru_victim_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of entries; power of two, >=2.
REQ-002 SHALL have parameter DEPTH, default $clog2(WIDTH): number of PLRU tree levels.
REQ-003 SHALL have port clk  input  1: clock, rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld  input  1: allocation request.
REQ-006 SHALL have port req_rdy  output  1: request accepted when req_vld&&req_rdy.
REQ-007 SHALL have port entry_vld  input  WIDTH: per-entry occupied flags.
REQ-008 SHALL have port entry_lock  input  WIDTH: per-entry pinned flags; pinned entries are never granted.
REQ-009 SHALL have port node_q  input  WIDTH-1: PLRU tree bits in heap order (root bit 0; level i, offset j at bit 2^i+j-1).
REQ-010 SHALL have port gnt_vld  output  1: grant valid.
REQ-011 SHALL have port gnt_rdy  input  1: grant consumed when gnt_vld&&gnt_rdy (fire).
REQ-012 SHALL have port gnt_oh  output  WIDTH: one-hot granted entry.
REQ-013 SHALL have port gnt_evict  output  1: granted entry was occupied at accept time.
REQ-014 SHALL have port touch_en  input  1: hit/use notification, single-cycle pulse.
REQ-015 SHALL have port touch_oh  input  WIDTH: one-hot touched entry.
REQ-016 SHALL have port plru_upd_en  output  1: tree update strobe to the PLRU node alloc_en.
REQ-017 SHALL have port plru_upd_oh  output  WIDTH: one-hot entry to the PLRU node v_alloc.

Function
REQ-018 SHALL implement FSM IDLE/GNT; IDLE: req_rdy=1, gnt_vld=0; GNT: req_rdy=0.
REQ-019 SHALL, in IDLE, hold req_rdy=0 when no eligible entry exists (all locked), without changing state.
REQ-020 SHALL, on accept, register the candidate into gnt_oh and gnt_evict and move to GNT next cycle.
REQ-021 SHALL pick the lowest-index entry with entry_vld=0 and eligible; gnt_evict=0.
REQ-022 SHALL otherwise walk the tree from root: bit=1 -> upper half, bit=0 -> lower half; gnt_evict=1.
REQ-023 SHALL, in the tree walk, take the opposite subtree when the indicated subtree has no eligible entry.
REQ-024 SHALL hold gnt_oh and gnt_evict stable in GNT until fire; the grant is not recomputed when inputs change.
REQ-025 SHALL assert gnt_vld in GNT only while the touch-pending register is empty.
REQ-026 SHALL return to IDLE on fire; minimum accept-to-accept interval is 2 cycles.
REQ-027 SHALL register update outputs: plru_upd_en/plru_upd_oh in cycle n+1 come from cycle n by priority: fire (gnt_oh), then pending touch, then touch_en.
REQ-028 SHALL capture a touch that lost arbitration into the one-deep pending register.
REQ-029 SHALL capture a new touch into pending in the same cycle the old pending entry is issued.
REQ-030 SHALL keep plru_upd_oh=0 whenever plru_upd_en=0.
REQ-031 SHALL accept the known starvation of grants when touch_en is asserted every cycle.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set state=IDLE, gnt_oh=0, gnt_evict=0, plru_upd_en=0, plru_upd_oh=0, touch pending empty.
REQ-033 SHALL drop an outstanding grant or pending touch when reset asserts mid-operation; no update is issued after reset.

Configuration
REQ-034 SHALL provide macro CMN_PLRU_VICTIM_LOCK_EN: when defined, entry_lock masks eligibility (REQ-008, REQ-019, REQ-023).
REQ-035 SHALL, when CMN_PLRU_VICTIM_LOCK_EN is undefined, ignore entry_lock: all entries are eligible, req_rdy=1 in IDLE, REQ-023 never applies; the port stays present.

Verification
REQ-036 SHALL cover: WIDTH=4, entry_vld=4'b1011, req -> gnt_oh=4'b0100, gnt_evict=0, plru_upd_oh=4'b0100 the cycle after fire.
REQ-037 SHALL cover: entry_vld=4'b1111, node_q=3'b001, req -> gnt_oh=4'b0100, gnt_evict=1.
REQ-038 SHALL cover, with LOCK_EN: entry_vld=4'b1111, node_q=3'b001, entry_lock=4'b1100 -> gnt_oh=4'b0001 (opposite subtree); entry_lock=4'b1111 -> req_rdy=0.
REQ-039 SHALL cover: touch_en with touch_oh=4'b0010 in the same cycle as fire -> alloc update at n+1, touch 4'b0010 at n+2.
REQ-040 SHALL cover: gnt_rdy=0 for 5 cycles -> gnt_oh stable throughout, no plru_upd_en pulse until fire.
REQ-041 SHALL cover: rst_n low while in GNT -> gnt_vld=0 and plru_upd_en=0 immediately; IDLE with req_rdy=1 after release.
